icache_rd_responder: RTL and testbench
======================================

ICACHE_RD_RESPONDER -- requirements
Module: icache_rd_responder

Interface
REQ-001 Parameter LAT, default 2: idle wait cycles between address acceptance and first RAM fetch (0..15).
REQ-002 Parameter LINE_WORDS, default 4: 32-bit beats per burst (one 16-byte cache line).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rstn  input  1  reset, synchronous and active-low.
REQ-005 i_arvalid  input  1  read-address request valid from the cache.
REQ-006 i_araddr  input  32  line address; bits [3:0] ignored.
REQ-007 i_arready  output  1  address accepted when high together with i_arvalid.
REQ-008 i_rvalid  output  1  read beat valid.
REQ-009 i_rdata  output  32  read beat data.
REQ-010 i_rlast  output  1  final beat of the burst.
REQ-011 i_rready  input  1  cache accepts current beat.
REQ-012 ram_en  output  1  backing-RAM read enable.
REQ-013 ram_addr  output  32  backing-RAM byte address, word aligned.
REQ-014 ram_rdata  input  32  RAM read data, valid the cycle after ram_en.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 States SHALL be IDLE, WAIT, FETCH, LOAD, RESP.
REQ-017 IDLE: i_arready=1; on i_arvalid, latch base={i_araddr[31:4],4'h0}, beat=0, wait counter=LAT; go WAIT if LAT>0, else FETCH.
REQ-018 WAIT: counter decrements each cycle; go FETCH in the cycle after it reaches 1.
REQ-019 FETCH: ram_en=1, ram_addr=base+4*beat for exactly one cycle; go LOAD.
REQ-020 LOAD: capture ram_rdata into data register at end of cycle; go RESP.
REQ-021 RESP: i_rvalid=1, i_rdata=data register, i_rlast=1 iff beat==LINE_WORDS-1.
REQ-022 RESP with i_rready=0: stay in RESP; i_rvalid, i_rdata, i_rlast held stable.
REQ-023 RESP with i_rready=1 and not last: beat+1, go FETCH; with last: go IDLE.
REQ-024 i_arready SHALL be 0 outside IDLE; no second request accepted mid-burst.
REQ-025 i_rvalid, i_rlast, ram_en SHALL be 0 in every state where not explicitly asserted; ram_addr=0 when ram_en=0.
REQ-026 Latency with LAT=L and i_rready held 1: first i_rvalid L+3 cycles after the handshake edge; subsequent beats every 3 cycles; burst length 3*LINE_WORDS+L cycles after handshake.
REQ-027 beat counter width SHALL be clog2(LINE_WORDS); addresses do not wrap within a line (base aligned).
REQ-028 i_arvalid deasserted before acceptance is not a request; no state change.

Reset
REQ-029 rstn=0 at a clock edge forces IDLE, beat=0, counter=0, data register=0, base=0.
REQ-030 Output values during reset: i_arready=0, i_rvalid=0, i_rlast=0, i_rdata=0, ram_en=0, ram_addr=0, busy=0; i_arready=1 from the first edge with rstn=1.
REQ-031 Reset mid-burst SHALL abandon the burst; no further beats issued.

Structure
REQ-032 Shared package icache_pkg SHALL hold LINE_WORDS, line offset width (4), and the responder state encoding.
REQ-033 No sub-module in RTL; the bench provides a sync-read RAM model line_ram_model.

Verification
REQ-034 LAT=2, request 0x0000_1234, RAM[a]=a, i_rready=1 -> beats 0x1230,0x1234,0x1238,0x123C; first i_rvalid 5 cycles after handshake; i_rlast only on 0x123C.
REQ-035 LAT=0, request 0x40 -> first i_rvalid 3 cycles after handshake; ram_addr sequence 0x40,0x44,0x48,0x4C, one ram_en pulse each.
REQ-036 Backpressure: hold i_rready=0 for 4 cycles on beat 2 -> i_rvalid/i_rdata/i_rlast stable, no ram_en, then burst completes normally.
REQ-037 i_arvalid asserted continuously through burst -> i_arready=0 until return to IDLE; second address accepted exactly the cycle after last-beat handshake.
REQ-038 rstn=0 during beat 1 of burst -> next cycle all outputs 0, state IDLE; new request 0x80 then returns a complete correct 4-beat burst.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared definitions for the instruction-cache read responder: line geometry,
// responder state encoding and address helpers.
package icache_pkg;

    localparam int unsigned ICACHE_LINE_WORDS = 4;
    localparam int unsigned LINE_OFF_W        = 4;

    typedef enum logic [2:0] {
        RSP_IDLE  = 3'd0,
        RSP_WAIT  = 3'd1,
        RSP_FETCH = 3'd2,
        RSP_LOAD  = 3'd3,
        RSP_RESP  = 3'd4
    } rsp_state_e;

    // Clears the byte offset inside a line so bursts always start aligned.
    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return addr & ~((32'd1 << LINE_OFF_W) - 32'd1);
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [31:0] beat);
        return base + (beat << 2);
    endfunction

endpackage

// File: rtl/icache_rd_responder_chk.sv
// Protocol properties for the read responder outputs, bound alongside an instance.
module icache_rd_responder_chk (
    input logic        clk,
    input logic        rstn,
    input logic        i_arready,
    input logic        i_rvalid,
    input logic [31:0] i_rdata,
    input logic        i_rlast,
    input logic        i_rready,
    input logic        ram_en,
    input logic [31:0] ram_addr,
    input logic        busy
);

    a_ready_not_busy: assert property (@(posedge clk) disable iff (!rstn) !(i_arready && busy));
    a_addr_zero_idle: assert property (@(posedge clk) disable iff (!rstn) !ram_en |-> ram_addr == 32'h0);
    a_addr_aligned:   assert property (@(posedge clk) disable iff (!rstn) ram_en |-> ram_addr[1:0] == 2'b00);
    a_beat_held:      assert property (@(posedge clk) disable iff (!rstn)
                                       (i_rvalid && !i_rready) |=> (i_rvalid && $stable(i_rdata) && $stable(i_rlast)));
    a_last_with_valid: assert property (@(posedge clk) disable iff (!rstn) i_rlast |-> i_rvalid);

endmodule

// File: rtl/icache_rd_responder.sv
// Serves one cache-line read burst at a time from a synchronous-read backing RAM,
// one word fetch per beat, with a programmable idle latency before the first fetch.
module icache_rd_responder
    import icache_pkg::*;
#(
    parameter int unsigned LAT        = 2,
    parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_arvalid,
    input  logic [31:0] i_araddr,
    output logic        i_arready,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    input  logic        i_rready,
    output logic        ram_en,
    output logic [31:0] ram_addr,
    input  logic [31:0] ram_rdata,
    output logic        busy
);

    localparam int unsigned BW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
    localparam logic [3:0]    LAT_INIT  = 4'(LAT);

    rsp_state_e     state_r;
    logic [31:0]    base_r;
    logic [BW-1:0]  beat_r;
    logic [3:0]     wait_cnt_r;
    logic [31:0]    data_r;
    logic           arready_r;
    logic           rvalid_r;
    logic           rlast_r;
    logic           ram_en_r;
    logic [31:0]    ram_addr_r;
    logic           busy_r;

    // Burst sequencer; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r    <= RSP_IDLE;
            base_r     <= 32'h0;
            beat_r     <= '0;
            wait_cnt_r <= 4'd0;
            data_r     <= 32'h0;
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b0;
            rlast_r    <= 1'b0;
            ram_en_r   <= 1'b0;
            ram_addr_r <= 32'h0;
            busy_r     <= 1'b0;
        end else begin
            ram_en_r   <= 1'b0;
            ram_addr_r <= 32'h0;
            rvalid_r   <= 1'b0;
            rlast_r    <= 1'b0;
            case (state_r)
                RSP_IDLE: begin
                    // The ready flag is registered, so the cycle right after reset never accepts.
                    if (arready_r && i_arvalid) begin
                        base_r     <= line_base(i_araddr);
                        beat_r     <= '0;
                        wait_cnt_r <= LAT_INIT;
                        arready_r  <= 1'b0;
                        busy_r     <= 1'b1;
                        if (LAT_INIT != 4'd0) begin
                            state_r <= RSP_WAIT;
                        end else begin
                            state_r    <= RSP_FETCH;
                            ram_en_r   <= 1'b1;
                            ram_addr_r <= line_base(i_araddr);
                        end
                    end else begin
                        arready_r <= 1'b1;
                        busy_r    <= 1'b0;
                    end
                end
                RSP_WAIT: begin
                    wait_cnt_r <= wait_cnt_r - 4'd1;
                    if (wait_cnt_r <= 4'd1) begin
                        state_r    <= RSP_FETCH;
                        ram_en_r   <= 1'b1;
                        ram_addr_r <= beat_addr(base_r, 32'(beat_r));
                    end else begin
                        state_r <= RSP_WAIT;
                    end
                end
                RSP_FETCH: begin
                    state_r <= RSP_LOAD;
                end
                RSP_LOAD: begin
                    data_r   <= ram_rdata;
                    state_r  <= RSP_RESP;
                    rvalid_r <= 1'b1;
                    rlast_r  <= (beat_r == LAST_BEAT);
                end
                RSP_RESP: begin
                    if (i_rready) begin
                        if (beat_r == LAST_BEAT) begin
                            state_r   <= RSP_IDLE;
                            arready_r <= 1'b1;
                            busy_r    <= 1'b0;
                        end else begin
                            beat_r     <= beat_r + BW'(1);
                            state_r    <= RSP_FETCH;
                            ram_en_r   <= 1'b1;
                            ram_addr_r <= beat_addr(base_r, 32'(beat_r + BW'(1)));
                        end
                    end else begin
                        state_r  <= RSP_RESP;
                        rvalid_r <= 1'b1;
                        rlast_r  <= rlast_r;
                    end
                end
                default: begin
                    state_r   <= RSP_IDLE;
                    arready_r <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign i_arready = arready_r;
    assign i_rvalid  = rvalid_r;
    assign i_rdata   = data_r;
    assign i_rlast   = rlast_r;
    assign ram_en    = ram_en_r;
    assign ram_addr  = ram_addr_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_icache_rd_responder.sv
// Directed bench: two responders (LAT=0 at index 0, LAT=2 at index 1) over a
// RAM model whose word at address a reads back as a.
module tb_icache_rd_responder;

    localparam int LW = 4;

    logic        clk;
    logic        rstn_a      [2];
    logic        arvalid_a   [2];
    logic [31:0] araddr_a    [2];
    logic        arready_a   [2];
    logic        rvalid_a    [2];
    logic [31:0] rdata_a     [2];
    logic        rlast_a     [2];
    logic        rready_a    [2];
    logic        ram_en_a    [2];
    logic [31:0] ram_addr_a  [2];
    logic [31:0] ram_rdata_a [2];
    logic        busy_a      [2];

    int          total = 0;
    int          bad   = 0;
    int          en_cnt [2] = '{0, 0};
    logic [31:0] alog0 [$];
    logic [31:0] alog1 [$];

    icache_rd_responder #(.LAT(0), .LINE_WORDS(LW)) dut0 (
        .clk(clk), .rstn(rstn_a[0]), .i_arvalid(arvalid_a[0]), .i_araddr(araddr_a[0]),
        .i_arready(arready_a[0]), .i_rvalid(rvalid_a[0]), .i_rdata(rdata_a[0]),
        .i_rlast(rlast_a[0]), .i_rready(rready_a[0]), .ram_en(ram_en_a[0]),
        .ram_addr(ram_addr_a[0]), .ram_rdata(ram_rdata_a[0]), .busy(busy_a[0])
    );

    icache_rd_responder #(.LAT(2), .LINE_WORDS(LW)) dut2 (
        .clk(clk), .rstn(rstn_a[1]), .i_arvalid(arvalid_a[1]), .i_araddr(araddr_a[1]),
        .i_arready(arready_a[1]), .i_rvalid(rvalid_a[1]), .i_rdata(rdata_a[1]),
        .i_rlast(rlast_a[1]), .i_rready(rready_a[1]), .ram_en(ram_en_a[1]),
        .ram_addr(ram_addr_a[1]), .ram_rdata(ram_rdata_a[1]), .busy(busy_a[1])
    );

    icache_rd_responder_chk chk2 (
        .clk(clk), .rstn(rstn_a[1]), .i_arready(arready_a[1]), .i_rvalid(rvalid_a[1]),
        .i_rdata(rdata_a[1]), .i_rlast(rlast_a[1]), .i_rready(rready_a[1]),
        .ram_en(ram_en_a[1]), .ram_addr(ram_addr_a[1]), .busy(busy_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync-read RAM model plus fetch logging for both instances.
    always @(posedge clk) begin : line_ram_model
        for (int k = 0; k < 2; k++) begin
            if (ram_en_a[k]) begin
                ram_rdata_a[k] <= ram_addr_a[k];
                en_cnt[k]      <= en_cnt[k] + 1;
            end
        end
        if (ram_en_a[0]) alog0.push_back(ram_addr_a[0]);
        if (ram_en_a[1]) alog1.push_back(ram_addr_a[1]);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rv(input int d, input bit hold, output int n);
        n = 1;
        while (!rvalid_a[d] && n < 64) begin
            if (hold) check_val("arready_mid_burst", 32'(arready_a[d]), 32'd0);
            tick();
            n++;
        end
    endtask

    task automatic start_req(input int d, input logic [31:0] a, input bit hold);
        arvalid_a[d] = 1'b1;
        araddr_a[d]  = a;
        check_val("arready_idle", 32'(arready_a[d]), 32'd1);
        tick();
        if (!hold) arvalid_a[d] = 1'b0;
    endtask

    // Collects a whole burst; entered just after the address handshake edge.
    task automatic collect(input int d, input logic [31:0] base, input int lat,
                           input int stall_beat, input int stall_n, input bit hold);
        int    n;
        int    e;
        string tg;
        for (int b = 0; b < LW; b++) begin
            wait_rv(d, hold, n);
            tg = (b == 0) ? "first_latency" : "beat_gap";
            check_val(tg, 32'(n), (b == 0) ? 32'(lat + 3) : 32'd3);
            if (n >= 64) return;
            check_val("rdata", rdata_a[d], base + 32'(4 * b));
            check_val("rlast", 32'(rlast_a[d]), (b == LW - 1) ? 32'd1 : 32'd0);
            check_val("busy_resp", 32'(busy_a[d]), 32'd1);
            check_val("arready_resp", 32'(arready_a[d]), 32'd0);
            if (b == stall_beat) begin
                rready_a[d] = 1'b0;
                e = en_cnt[d];
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    check_val("stall_rvalid", 32'(rvalid_a[d]), 32'd1);
                    check_val("stall_rdata", rdata_a[d], base + 32'(4 * b));
                    check_val("stall_rlast", 32'(rlast_a[d]), (b == LW - 1) ? 32'd1 : 32'd0);
                end
                check_val("stall_no_ram_en", 32'(en_cnt[d]), 32'(e));
                rready_a[d] = 1'b1;
            end
            tick();
        end
        check_val("done_busy", 32'(busy_a[d]), 32'd0);
        check_val("done_arready", 32'(arready_a[d]), 32'd1);
        check_val("done_rvalid", 32'(rvalid_a[d]), 32'd0);
    endtask

    task automatic check_log(input int d, input logic [31:0] base, input int s0);
        logic [31:0] v;
        for (int i = 0; i < LW; i++) begin
            v = (d == 0) ? ((s0 + i < alog0.size()) ? alog0[s0 + i] : 32'hDEAD_DEAD)
                         : ((s0 + i < alog1.size()) ? alog1[s0 + i] : 32'hDEAD_DEAD);
            check_val("ram_addr_seq", v, base + 32'(4 * i));
        end
        check_val("ram_en_count", (d == 0) ? 32'(alog0.size() - s0) : 32'(alog1.size() - s0), 32'(LW));
    endtask

    task automatic check_all_zero(input int d);
        check_val("rst_arready", 32'(arready_a[d]), 32'd0);
        check_val("rst_rvalid", 32'(rvalid_a[d]), 32'd0);
        check_val("rst_rlast", 32'(rlast_a[d]), 32'd0);
        check_val("rst_rdata", rdata_a[d], 32'h0);
        check_val("rst_ram_en", 32'(ram_en_a[d]), 32'd0);
        check_val("rst_ram_addr", ram_addr_a[d], 32'h0);
        check_val("rst_busy", 32'(busy_a[d]), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int s0;
        int n;
        for (int k = 0; k < 2; k++) begin
            rstn_a[k] = 1'b0; arvalid_a[k] = 1'b0; araddr_a[k] = 32'h0; rready_a[k] = 1'b1;
        end
        tick();
        tick();
        check_all_zero(0);
        check_all_zero(1);

        // A request present on the first post-reset edge meets arready=0 and is ignored.
        arvalid_a[1] = 1'b1;
        araddr_a[1]  = 32'h0000_9990;
        rstn_a[0]    = 1'b1;
        rstn_a[1]    = 1'b1;
        tick();
        check_val("arready_after_rst", 32'(arready_a[1]), 32'd1);
        check_val("arready_after_rst0", 32'(arready_a[0]), 32'd1);
        arvalid_a[1] = 1'b0;
        tick();
        check_val("no_req_busy", 32'(busy_a[1]), 32'd0);
        check_val("no_req_fetch", 32'(alog1.size()), 32'd0);

        // LAT=2 basic burst from an unaligned address.
        s0 = alog1.size();
        start_req(1, 32'h0000_1234, 1'b0);
        collect(1, 32'h0000_1230, 2, -1, 0, 1'b0);
        check_log(1, 32'h0000_1230, s0);

        // LAT=0 burst.
        s0 = alog0.size();
        start_req(0, 32'h0000_0040, 1'b0);
        collect(0, 32'h0000_0040, 0, -1, 0, 1'b0);
        check_log(0, 32'h0000_0040, s0);

        // Backpressure on beat 2.
        s0 = alog1.size();
        start_req(1, 32'h0000_2008, 1'b0);
        collect(1, 32'h0000_2000, 2, 2, 4, 1'b0);
        check_log(1, 32'h0000_2000, s0);

        // Request held through the burst; next address taken right after the last beat.
        start_req(1, 32'h0000_3000, 1'b1);
        collect(1, 32'h0000_3000, 2, -1, 0, 1'b1);
        araddr_a[1] = 32'h0000_4004;
        tick();
        arvalid_a[1] = 1'b0;
        check_val("back_to_back_busy", 32'(busy_a[1]), 32'd1);
        collect(1, 32'h0000_4000, 2, -1, 0, 1'b0);

        // Reset during beat 1 abandons the burst.
        start_req(1, 32'h0000_5000, 1'b0);
        wait_rv(1, 1'b0, n);
        check_val("rst_burst_b0", rdata_a[1], 32'h0000_5000);
        tick();
        wait_rv(1, 1'b0, n);
        check_val("rst_burst_b1", rdata_a[1], 32'h0000_5004);
        rstn_a[1] = 1'b0;
        tick();
        check_all_zero(1);
        rstn_a[1] = 1'b1;
        s0 = alog1.size();
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("post_rst_rvalid", 32'(rvalid_a[1]), 32'd0);
        end
        check_val("post_rst_no_fetch", 32'(alog1.size()), 32'(s0));
        check_val("post_rst_idle", 32'(arready_a[1]), 32'd1);
        start_req(1, 32'h0000_0080, 1'b0);
        collect(1, 32'h0000_0080, 2, -1, 0, 1'b0);
        check_log(1, 32'h0000_0080, s0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
